keypad_scanner: RTL



---
 rtl/keypad_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/keypad_scanner.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, key legend and helpers for keypad_scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Indexed by {row, col}; '*' reports as 0xE and '#' as 0xF
    localparam logic [3:0] KEY_LEGEND [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] col_index(input logic [3:0] col_n);
        case (col_n)
            4'b1110: col_index = 2'd0;
            4'b1101: col_index = 2'd1;
            4'b1011: col_index = 2'd2;
            default: col_index = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        if (!rows[0])      lowest_low_row = 2'd0;
        else if (!rows[1]) lowest_low_row = 2'd1;
        else if (!rows[2]) lowest_low_row = 2'd2;
        else               lowest_low_row = 2'd3;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous inputs, parameterised width
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = i_D;
        sync_d = meta_q;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_Q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce; KEYPAD_REPEAT_EN adds auto-repeat while held
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLKS_PER_COL  = 250,
    parameter int DEBOUNCE_CLKS = 250000,
    parameter int REPEAT_CLKS   = 12500000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Row,
    output logic [3:0] o_Col,
    output logic [3:0] o_Key,
    output logic       o_Key_DV,
    output logic       o_Key_Held
);

    localparam int CNT_MAX = (DEBOUNCE_CLKS > CLKS_PER_COL) ? DEBOUNCE_CLKS : CLKS_PER_COL;
    localparam int CW      = $clog2(CNT_MAX);

    if (CLKS_PER_COL < 4) begin : g_bad_settle
        $error("CLKS_PER_COL must be >= 4");
    end
    if (DEBOUNCE_CLKS < 2 || REPEAT_CLKS < 2) begin : g_bad_intervals
        $error("DEBOUNCE_CLKS and REPEAT_CLKS must be >= 2");
    end

    logic [3:0]    row_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    row_sel_q, row_sel_d;
    logic [3:0]    key_q, key_d;
    logic          dv_q, dv_d;
    logic          held_q, held_d;
    logic          latched_high;
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CLKS);
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_D     (i_Row),
        .o_Q     (row_s)
    );

    assign latched_high = row_s[row_sel_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_sel_d = row_sel_q;
        key_d     = key_q;
        dv_d      = 1'b0;
        held_d    = held_q;
`ifdef KEYPAD_REPEAT_EN
        rpt_d     = rpt_q;
`endif
        unique case (state_q)
            ST_SCAN: begin
                if (cnt_q == CW'(CLKS_PER_COL - 1)) begin
                    cnt_d = '0;
                    if (row_s != 4'hF) begin
                        row_sel_d = lowest_low_row(row_s);
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_d = {col_q[2:0], col_q[3]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                // A bounce retries the same column from a fresh settle period
                if (latched_high) begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end else if (cnt_q == CW'(DEBOUNCE_CLKS - 1)) begin
                    cnt_d   = '0;
                    key_d   = KEY_LEGEND[{row_sel_q, col_index(col_q)}];
                    dv_d    = 1'b1;
                    held_d  = 1'b1;
                    state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                    rpt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (latched_high) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                    rpt_d   = '0;
                end else if (rpt_q == RW'(REPEAT_CLKS - 1)) begin
                    rpt_d = '0;
                    dv_d  = 1'b1;
                end else begin
                    rpt_d = rpt_q + 1'b1;
`endif
                end
            end
            ST_RELEASE: begin
                if (!latched_high) begin
                    state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                    rpt_d   = '0;
`endif
                end else if (cnt_q == CW'(DEBOUNCE_CLKS - 1)) begin
                    cnt_d   = '0;
                    held_d  = 1'b0;
                    col_d   = {col_q[2:0], col_q[3]};
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_SCAN;
            cnt_q     <= '0;
            col_q     <= COL_RESET;
            row_sel_q <= 2'd0;
            key_q     <= 4'h0;
            dv_q      <= 1'b0;
            held_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_sel_q <= row_sel_d;
            key_q     <= key_d;
            dv_q      <= dv_d;
            held_q    <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q     <= rpt_d;
`endif
        end
    end

    assign o_Col      = col_q;
    assign o_Key      = key_q;
    assign o_Key_DV   = dv_q;
    assign o_Key_Held = held_q;

endmodule
